// File: rtl/ppc_excep_unit.sv
// ppc_excep_unit: exception sequencer.
// Picks the highest-priority fault or interrupt cause and presents its code to
// the controller until it acknowledges. It then saves SRR0/SRR1, clears the
// MSR and redirects fetch to the vector. It also handles rfi by restoring the
// MSR from SRR1 and redirecting to SRR0.
module ppc_excep_unit #(
  parameter logic [31:0] VEC_BASE    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isTraped,
  input  logic        isUndefined,
  input  logic        isPriveleged,
  input  logic        isLoad,
  input  logic        isStore,
  input  logic        isFetch,
  input  logic        isMoveSpr,
  input  logic        sc,
  input  logic        extInt,
  input  logic [31:0] epc,
  input  logic [31:0] npc,
  input  logic        rfi,
  input  logic        msrWe,
  input  logic [1:0]  msrWd,
  input  logic        ack,
  output logic [3:0]  excepCode,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirectPc,
  output logic [31:0] srr0,
  output logic [31:0] srr1,
  output logic        msrEE,
  output logic        msrPR,
  output logic        ackTimeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SAVE  = 2'd2,
    ST_REDIR = 2'd3
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  // Fixed-priority cause encoder: ISI > ILL > PRIV > TRAP > SC > DSI > EXT.
  function automatic logic [3:0] sel_cause(
    input logic f_isi, input logic f_ill, input logic f_priv, input logic f_trap,
    input logic f_sc, input logic f_dsi, input logic f_ext);
    if (f_isi)       sel_cause = 4'd1;
    else if (f_ill)  sel_cause = 4'd2;
    else if (f_priv) sel_cause = 4'd3;
    else if (f_trap) sel_cause = 4'd4;
    else if (f_sc)   sel_cause = 4'd5;
    else if (f_dsi)  sel_cause = 4'd6;
    else if (f_ext)  sel_cause = 4'd7;
    else             sel_cause = 4'd0;
  endfunction

  // Vector offset for each cause code.
  function automatic logic [31:0] vec_offset(input logic [3:0] code);
    case (code)
      4'd1:    vec_offset = 32'h0000_0400;
      4'd2:    vec_offset = 32'h0000_0700;
      4'd3:    vec_offset = 32'h0000_0700;
      4'd4:    vec_offset = 32'h0000_0700;
      4'd5:    vec_offset = 32'h0000_0C00;
      4'd6:    vec_offset = 32'h0000_0300;
      4'd7:    vec_offset = 32'h0000_0500;
      default: vec_offset = 32'h0000_0000;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  code_q, code_d;
  logic [31:0] save_pc_q, save_pc_d;
  logic [31:0] vec_q, vec_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] srr0_q, srr0_d;
  logic [31:0] srr1_q, srr1_d;
  logic        ee_q, ee_d;
  logic        pr_q, pr_d;
  logic        to_q, to_d;
  logic [3:0]  excep_code_q, excep_code_d;
  logic        stall_q, stall_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [3:0]  cause_s;

  // SC and EXT resume after the instruction; all other causes restart it.
  function automatic logic use_npc(input logic [3:0] code);
    use_npc = (code == 4'd5) || (code == 4'd7);
  endfunction

  // Current-cycle cause, gated by the live MSR bits.
  always_comb begin
    cause_s = sel_cause(isFetch, isUndefined, pr_q & (isPriveleged | isMoveSpr),
                        isTraped, sc, isLoad | isStore, extInt & ee_q);
  end

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    save_pc_d     = save_pc_q;
    vec_d         = vec_q;
    cnt_d         = cnt_q;
    srr0_d        = srr0_q;
    srr1_d        = srr1_q;
    ee_d          = ee_q;
    pr_d          = pr_q;
    to_d          = to_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (cause_s != 4'd0) begin
          code_d    = cause_s;
          save_pc_d = use_npc(cause_s) ? npc : epc;
          vec_d     = VEC_BASE + vec_offset(cause_s);
          cnt_d     = 8'd0;
          state_d   = ST_REQ;
        end else if (rfi) begin
          redirect_d    = 1'b1;
          redirect_pc_d = srr0_q;
          ee_d          = srr1_q[15];
          pr_d          = srr1_q[14];
        end else if (msrWe) begin
          ee_d = msrWd[1];
          pr_d = msrWd[0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ack || (cnt_q == CNT_LAST)) begin
          state_d = ST_SAVE;
          if (!ack) begin
            to_d = 1'b1;
          end else begin
            to_d = to_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SAVE: begin
        srr0_d        = save_pc_q;
        srr1_d        = {16'h0000, ee_q, pr_q, 10'b00_0000_0000, code_q};
        ee_d          = 1'b0;
        pr_d          = 1'b0;
        redirect_d    = 1'b1;
        redirect_pc_d = vec_q;
        state_d       = ST_REDIR;
      end
      ST_REDIR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    excep_code_d = (state_d == ST_REQ) ? code_d : 4'd0;
    stall_d      = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      code_q        <= 4'd0;
      save_pc_q     <= 32'h0;
      vec_q         <= 32'h0;
      cnt_q         <= 8'd0;
      srr0_q        <= 32'h0;
      srr1_q        <= 32'h0;
      ee_q          <= 1'b0;
      pr_q          <= 1'b0;
      to_q          <= 1'b0;
      excep_code_q  <= 4'd0;
      stall_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      save_pc_q     <= save_pc_d;
      vec_q         <= vec_d;
      cnt_q         <= cnt_d;
      srr0_q        <= srr0_d;
      srr1_q        <= srr1_d;
      ee_q          <= ee_d;
      pr_q          <= pr_d;
      to_q          <= to_d;
      excep_code_q  <= excep_code_d;
      stall_q       <= stall_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign excepCode  = excep_code_q;
  assign stall      = stall_q;
  assign redirect   = redirect_q;
  assign redirectPc = redirect_pc_q;
  assign srr0       = srr0_q;
  assign srr1       = srr1_q;
  assign msrEE      = ee_q;
  assign msrPR      = pr_q;
  assign ackTimeout = to_q;

endmodule

// File: tb/tb_ppc_excep_unit.sv
// Directed self-checking bench for ppc_excep_unit.
module tb_ppc_excep_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        isTraped, isUndefined, isPriveleged, isLoad, isStore;
  logic        isFetch, isMoveSpr, sc, extInt, rfi, msrWe, ack;
  logic [31:0] epc, npc;
  logic [1:0]  msrWd;
  logic [3:0]  excepCode;
  logic        stall, redirect, msrEE, msrPR, ackTimeout;
  logic [31:0] redirectPc, srr0, srr1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_req;

  always #5 clk = ~clk;

  ppc_excep_unit #(.VEC_BASE(32'h0000_0000), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .isTraped(isTraped), .isUndefined(isUndefined), .isPriveleged(isPriveleged),
    .isLoad(isLoad), .isStore(isStore), .isFetch(isFetch), .isMoveSpr(isMoveSpr),
    .sc(sc), .extInt(extInt), .epc(epc), .npc(npc), .rfi(rfi),
    .msrWe(msrWe), .msrWd(msrWd), .ack(ack),
    .excepCode(excepCode), .stall(stall), .redirect(redirect),
    .redirectPc(redirectPc), .srr0(srr0), .srr1(srr1),
    .msrEE(msrEE), .msrPR(msrPR), .ackTimeout(ackTimeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {isTraped, isUndefined, isPriveleged, isLoad, isStore} = 5'b0;
    {isFetch, isMoveSpr, sc, extInt, rfi, msrWe, ack} = 7'b0;
    epc = 32'h0; npc = 32'h0; msrWd = 2'b00;
    tick(); tick();
    check_eq("rst_code", {28'h0, excepCode}, 32'h0);
    check_eq("rst_stall", {31'h0, stall}, 32'h0);
    check_eq("rst_redir", {31'h0, redirect}, 32'h0);
    check_eq("rst_srr1", srr1, 32'h0);
    rst = 1'b0;
    tick();

    // Undefined instruction, ack one cycle after code appears.
    isUndefined = 1'b1; epc = 32'h100; npc = 32'h104;
    tick();                               // edge 0 sample -> edge 1 REQ
    isUndefined = 1'b0;
    check_eq("ill_code", {28'h0, excepCode}, 32'h2);
    check_eq("ill_stall", {31'h0, stall}, 32'h1);
    tick();                               // edge 2, still REQ
    check_eq("ill_code2", {28'h0, excepCode}, 32'h2);
    ack = 1'b1;
    tick();                               // edge 3 SAVE
    ack = 1'b0;
    check_eq("ill_save_code", {28'h0, excepCode}, 32'h0);
    check_eq("ill_save_redir", {31'h0, redirect}, 32'h0);
    tick();                               // edge 4 REDIR
    check_eq("ill_redir", {31'h0, redirect}, 32'h1);
    check_eq("ill_rpc", redirectPc, 32'h700);
    check_eq("ill_srr0", srr0, 32'h100);
    check_eq("ill_srr1", srr1, 32'h2);
    tick();                               // edge 5 IDLE
    check_eq("ill_idle_redir", {31'h0, redirect}, 32'h0);
    check_eq("ill_idle_stall", {31'h0, stall}, 32'h0);

    // MSR write, then SC together with a load: SC wins.
    msrWe = 1'b1; msrWd = 2'b11;
    tick();
    msrWe = 1'b0;
    check_eq("msr_ee", {31'h0, msrEE}, 32'h1);
    check_eq("msr_pr", {31'h0, msrPR}, 32'h1);
    sc = 1'b1; isLoad = 1'b1; epc = 32'h200; npc = 32'h204;
    tick();
    sc = 1'b0; isLoad = 1'b0;
    check_eq("sc_code", {28'h0, excepCode}, 32'h5);
    tick(); ack = 1'b1;
    tick(); ack = 1'b0;
    tick();
    check_eq("sc_redir", {31'h0, redirect}, 32'h1);
    check_eq("sc_rpc", redirectPc, 32'hC00);
    check_eq("sc_srr0", srr0, 32'h204);
    check_eq("sc_srr1", srr1, 32'hC005);
    check_eq("sc_ee", {31'h0, msrEE}, 32'h0);
    check_eq("sc_pr", {31'h0, msrPR}, 32'h0);
    tick();

    // External interrupt masked, then enabled.
    extInt = 1'b1; npc = 32'h80; epc = 32'h7C;
    tick(); tick();
    check_eq("ext_masked_stall", {31'h0, stall}, 32'h0);
    check_eq("ext_masked_code", {28'h0, excepCode}, 32'h0);
    msrWe = 1'b1; msrWd = 2'b10;
    tick();                               // EE now 1, no REQ yet
    msrWe = 1'b0;
    check_eq("ext_we_stall", {31'h0, stall}, 32'h0);
    tick();
    extInt = 1'b0;
    check_eq("ext_code", {28'h0, excepCode}, 32'h7);
    tick(); ack = 1'b1;
    tick(); ack = 1'b0;
    tick();
    check_eq("ext_rpc", redirectPc, 32'h500);
    check_eq("ext_srr0", srr0, 32'h80);
    check_eq("ext_srr1", srr1, 32'h8007);
    tick();

    // Timeout: ack held low, REQ lasts exactly 15 cycles.
    isTraped = 1'b1; epc = 32'h300;
    tick();
    isTraped = 1'b0;
    check_eq("to_code", {28'h0, excepCode}, 32'h4);
    n_req = 0;
    while (excepCode == 4'd4 && n_req < 40) begin
      n_req++;
      tick();
    end
    check_eq("to_len", n_req, 32'd15);
    check_eq("to_flag", {31'h0, ackTimeout}, 32'h1);
    check_eq("to_save_stall", {31'h0, stall}, 32'h1);
    tick();
    check_eq("to_redir", {31'h0, redirect}, 32'h1);
    check_eq("to_rpc", redirectPc, 32'h700);
    check_eq("to_srr0", srr0, 32'h300);
    check_eq("to_srr1", srr1, 32'h4);
    tick();

    // Exception with EE=1 so srr1[15:14]=10, then rfi.
    msrWe = 1'b1; msrWd = 2'b10;
    tick();
    msrWe = 1'b0;
    isUndefined = 1'b1; epc = 32'h500;
    tick();
    isUndefined = 1'b0;
    tick(); ack = 1'b1;
    tick(); ack = 1'b0;
    tick();
    check_eq("pre_rfi_srr1", srr1, 32'h8002);
    tick();
    rfi = 1'b1;
    tick();
    rfi = 1'b0;
    check_eq("rfi_redir", {31'h0, redirect}, 32'h1);
    check_eq("rfi_rpc", redirectPc, 32'h500);
    check_eq("rfi_ee", {31'h0, msrEE}, 32'h1);
    check_eq("rfi_pr", {31'h0, msrPR}, 32'h0);
    tick();
    check_eq("rfi_redir_end", {31'h0, redirect}, 32'h0);

    // rfi with a trap in the same cycle: trap wins.
    rfi = 1'b1; isTraped = 1'b1; epc = 32'h600;
    tick();
    rfi = 1'b0; isTraped = 1'b0;
    check_eq("rfitrap_redir", {31'h0, redirect}, 32'h0);
    check_eq("rfitrap_code", {28'h0, excepCode}, 32'h4);
    tick(); ack = 1'b1;
    tick(); ack = 1'b0;
    tick();
    check_eq("rfitrap_srr0", srr0, 32'h600);
    check_eq("rfitrap_rpc", redirectPc, 32'h700);
    tick();

    // Reset while in SAVE.
    isFetch = 1'b1; epc = 32'h700;
    tick();
    isFetch = 1'b0;
    check_eq("isi_code", {28'h0, excepCode}, 32'h1);
    ack = 1'b1;
    tick();                               // SAVE
    ack = 1'b0;
    check_eq("isi_save_stall", {31'h0, stall}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_save_stall", {31'h0, stall}, 32'h0);
    check_eq("rst_save_redir", {31'h0, redirect}, 32'h0);
    check_eq("rst_save_srr0", srr0, 32'h0);
    check_eq("rst_save_flag", {31'h0, ackTimeout}, 32'h0);
    tick();
    check_eq("rst_after_redir", {31'h0, redirect}, 32'h0);
    check_eq("rst_after_stall", {31'h0, stall}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ppc_excep_unit.md
# ppc_excep_unit

Exception sequencer downstream of the toy controller's registered exception flags. It prioritises the per-instruction fault flags (trap, undefined, privileged, load, store, fetch, move-SPR, system call) and the external interrupt into a single exception code. It drives that code to the controller and waits for the controller's `ack`. It then saves SRR0/SRR1, updates the MSR and redirects fetch to the exception vector. It also executes `rfi` (return from interrupt) by restoring the MSR and redirecting to SRR0.

## Interface
- `VEC_BASE`, 32'h0000_0000, base address added to every vector offset.
- `ACK_TIMEOUT`, 15, maximum cycles spent in REQ waiting for `ack` (1..255).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `isTraped`, `isUndefined`, `isPriveleged`, `isLoad`, `isStore`, `isFetch`, `isMoveSpr`, `sc` in 1 each: registered fault flags from the controller.
- `extInt` in 1: external interrupt request, level.
- `epc` in 32: PC of the instruction owning the flags.
- `npc` in 32: PC of the following instruction.
- `rfi` in 1: return-from-interrupt instruction in this cycle.
- `msrWe` in 1: MSR write enable. `msrWd` in 2: MSR write data, {EE,PR}.
- `ack` in 1: exception acknowledge from the controller.
- `excepCode` out 4: held exception code; 0 means NONE.
- `stall` out 1: pipeline hold.
- `redirect` out 1: one-cycle fetch redirect.
- `redirectPc` out 32: redirect target, valid while `redirect`=1.
- `srr0`, `srr1` out 32 each: save/restore registers.
- `msrEE`, `msrPR` out 1 each: MSR bits.
- `ackTimeout` out 1: sticky flag, set when the REQ wait times out.

## Operation
- Cause codes, vector offsets and SRR0 value:
  - ISI = 1 (`isFetch`): offset 0x400, SRR0 = `epc`.
  - ILL = 2 (`isUndefined`): offset 0x700, SRR0 = `epc`.
  - PRIV = 3 (`msrPR` & (`isPriveleged` | `isMoveSpr`)): offset 0x700, SRR0 = `epc`.
  - TRAP = 4 (`isTraped`): offset 0x700, SRR0 = `epc`.
  - SC = 5 (`sc`): offset 0xC00, SRR0 = `npc`.
  - DSI = 6 (`isLoad` | `isStore`): offset 0x300, SRR0 = `epc`.
  - EXT = 7 (`extInt` & `msrEE`): offset 0x500, SRR0 = `npc`.
- Priority is strictly ISI > ILL > PRIV > TRAP > SC > DSI > EXT. Only the winner is taken; lower causes are dropped.
- FSM states: IDLE, REQ, SAVE, REDIR.
- IDLE, a cause is present:
  - Latch the code, the selected SRR0 value and the vector address (`VEC_BASE` + offset).
  - Clear the wait counter.
  - Go to REQ.
- IDLE, no cause, `rfi`=1:
  - Next cycle: `redirect`=1 and `redirectPc`=`srr0`.
  - {EE,PR} <= `srr1`[15:14].
  - Stay in IDLE.
- IDLE, no cause, no `rfi`, `msrWe`=1: {EE,PR} <= `msrWd`.
- REQ:
  - `excepCode` = latched code.
  - Go to SAVE when `ack`=1 or the counter reaches `ACK_TIMEOUT`-1. A timeout also sets `ackTimeout`.
  - Otherwise increment the counter.
- SAVE:
  - `srr0` <= latched SRR0 value.
  - `srr1` <= {16'b0, EE, PR, 10'b0, code} (bits 15:14 = old EE/PR, bits 3:0 = code).
  - EE <= 0, PR <= 0.
  - Go to REDIR.
- REDIR: `redirect`=1, `redirectPc` = latched vector. Go to IDLE.
- `stall`=1 in REQ, SAVE and REDIR. `stall`=0 in IDLE.
- `excepCode`=0 in every state except REQ.
- While not in IDLE:
  - New causes, `rfi` and `msrWe` are ignored.
  - `extInt` is not latched; it is re-sampled on return to IDLE.
- Simultaneous events in IDLE: a cause beats `rfi`, and `rfi` beats `msrWe`.
- All arithmetic is 32-bit and wraps modulo 2^32 (`VEC_BASE` + offset).

## Timing
- Reset: FSM to IDLE. `srr0`, `srr1`, `redirectPc`, `excepCode`, counter = 0. `msrEE`=`msrPR`=0. `stall`, `redirect`, `ackTimeout` = 0.
- Reset takes effect from any state. Latched state is discarded and no redirect is issued.
- `excepCode`, `stall`, `redirect` and `redirectPc` are all registered outputs.
- Nominal exception, cause sampled in IDLE at edge 0:
  - Edge 1: REQ, `excepCode`≠0.
  - The controller registers `ack`, which is seen high after edge 2.
  - Edge 3: SAVE.
  - Edge 4: REDIR, `redirect`=1.
  - Edge 5: IDLE.
  - Latency from cause to redirect pulse: 4 cycles.
- `srr0`/`srr1`/MSR update at the SAVE→REDIR edge, so they are visible during the redirect pulse.
- Timeout path: REQ lasts exactly `ACK_TIMEOUT` cycles.
- `rfi` latency: the redirect pulse and MSR restore occur in the cycle after `rfi` is sampled.
- Back-to-back: a cause present in the first IDLE cycle after REDIR enters REQ immediately.

## Test plan
- `isUndefined`=1, `epc`=0x100, `ack` returned 1 cycle after `excepCode` → `excepCode`=2, `srr0`=0x100, `srr1`[3:0]=2, `redirect` with `redirectPc`=0x700 four cycles after the cause.
- `sc`=1, `isLoad`=1, `npc`=0x204, `msrWd`=2'b11 written earlier → SC wins: `srr0`=0x204, `srr1`=0xC005, EE=PR=0 after SAVE, `redirectPc`=0xC00.
- `extInt`=1 with EE=0 → no REQ. Set EE via `msrWe`, `npc`=0x80 → code 7, `redirectPc`=0x500, `srr0`=0x80.
- `ack` held 0 → REQ lasts 15 cycles, `ackTimeout`=1, and SAVE/REDIR still occur.
- After an exception, `rfi` with `srr1`[15:14]=2'b10 → `redirectPc`=`srr0`, EE=1, PR=0. `rfi` together with `isTraped` → TRAP taken, `rfi` ignored.
- `rst` asserted in SAVE → next cycle IDLE, all outputs 0, no `redirect`.
